// File: rtl/fod_spi_pkg.sv
// Shared constants for the FOD SPI register slave: register map, reset image, frame layout
// and FSM state encodings.
package fod_spi_pkg;

    localparam logic [6:0] ADDR_CTRL    = 7'h00;
    localparam logic [6:0] ADDR_FCW     = 7'h01;
    localparam logic [6:0] ADDR_PCAL    = 7'h02;
    localparam logic [6:0] ADDR_INL     = 7'h03;
    localparam logic [6:0] ADDR_KDTC_BC = 7'h04;
    localparam logic [6:0] ADDR_KDTC_D  = 7'h05;
    localparam logic [6:0] ADDR_ID      = 7'h7F;

    localparam logic [9:0]  RST_CTRL    = 10'h036;
    localparam logic [23:0] RST_FCW     = 24'h04C000;
    localparam logic [22:0] RST_PCAL    = 23'h200000;
    localparam logic [18:0] RST_INL     = 19'h6FA0F;
    localparam logic [19:0] RST_KDTC_BC = 20'h30D86;
    localparam logic [9:0]  RST_KDTC_D  = 10'h000;

    localparam int unsigned FRM_RW_BIT   = 31;
    localparam int unsigned FRM_ADDR_MSB = 30;
    localparam int unsigned FRM_ADDR_LSB = 24;
    localparam logic [5:0]  CMD_BITS     = 6'd8;
    localparam logic [5:0]  FRAME_BITS   = 6'd32;

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_CMD  = 2'd1;
    localparam fsm_state_t ST_DATA = 2'd2;
    localparam fsm_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/fod_spi_slave_if.sv
// SPI pin bundle between an off-chip master and the FOD register slave.
interface fod_spi_slave_if;
    logic SCLK;
    logic CSN;
    logic MOSI;
    logic MISO;
    logic MISO_OE;

    modport master (output SCLK, CSN, MOSI, input MISO, MISO_OE);
    modport slave  (input SCLK, CSN, MOSI, output MISO, MISO_OE);
endinterface

// File: rtl/fod_spi_sync.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall pulses on the synchronized value.
module fod_spi_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Chain resets low so a CSN already low at reset release yields no fall edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;
endmodule

// File: rtl/fod_spi_slave.sv
// Mode-0 SPI register slave holding all FOD control registers; 32-bit frames of
// R/nW, 7-bit address, 24-bit data, committed atomically on CSN rise.
module fod_spi_slave #(
    parameter int unsigned WI          = 7,
    parameter int unsigned WF          = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [23:0] ID_VALUE    = 24'hF0D100
) (
    input  logic                 CLK,
    input  logic                 NARST,
    fod_spi_slave_if.slave       spi,
    output logic                 WR_STB,
    output logic [6:0]           WR_ADDR,
    output logic [WI+WF-1:0]     FCW_FOD,
    output logic                 SYS_EN,
    output logic                 DSM_SYNC_NRST_EN,
    output logic                 NCO_SYNC_NRST_EN,
    output logic                 FREQ_HOP,
    output logic                 RT_EN,
    output logic                 PCALI_EN,
    output logic                 FREQ_C_EN,
    output logic                 FREQ_C_MODE,
    output logic                 DTCCALI_EN,
    output logic                 OFSTCALI_EN,
    output logic [4:0]           FREQ_C_KS,
    output logic [9:0]           PHASE_CTRL,
    output logic [2:0]           PCALI_FREQDOWN,
    output logic [4:0]           PCALI_KS,
    output logic [1:0]           PSEG,
    output logic [1:0]           CALIORDER,
    output logic [4:0]           KB,
    output logic [4:0]           KC,
    output logic [4:0]           KD,
    output logic [9:0]           KDTCB_INIT,
    output logic [9:0]           KDTCC_INIT,
    output logic [9:0]           KDTCD_INIT
);
    import fod_spi_pkg::*;

    localparam int unsigned FcwW = WI + WF;

    logic sclk_rise, sclk_fall, csn_rise, csn_fall, mosi_s;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

    fsm_state_t  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d, cnt_inc;
    logic [31:0] rx_q, rx_d, rx_shift;
    logic [23:0] tx_q, tx_d, rd_data;
    logic        rd_q, rd_d, bad_q, bad_d;
    logic        wr_stb_q, wr_stb_d;
    logic [6:0]  wr_addr_q, wr_addr_d;
    logic [9:0]  ctrl_q, ctrl_d, kdtc_d_q, kdtc_d_d;
    logic [FcwW-1:0] fcw_q, fcw_d;
    logic [22:0] pcal_q, pcal_d;
    logic [18:0] inl_q, inl_d;
    logic [19:0] kdtc_bc_q, kdtc_bc_d;
    logic        unused_data_msb;

    fod_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(CLK), .rst_n(NARST), .d_i(spi.SCLK), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    fod_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_csn_sync (
        .clk(CLK), .rst_n(NARST), .d_i(spi.CSN), .rise_o(csn_rise), .fall_o(csn_fall)
    );

    // MOSI shares the SCLK pipeline depth so each sample lines up with its rise pulse.
    assign mosi_sync_d     = {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
    assign mosi_s          = mosi_sync_q[SYNC_STAGES-1];
    assign rx_shift        = {rx_q[30:0], mosi_s};
    assign cnt_inc         = cnt_q + 6'd1;
    assign unused_data_msb = rx_q[23];

    always_comb begin
        rd_data = '0;
        case (rx_shift[6:0])
            ADDR_CTRL:    rd_data = {14'd0, ctrl_q};
            ADDR_FCW:     rd_data = 24'(fcw_q);
            ADDR_PCAL:    rd_data = {1'b0, pcal_q};
            ADDR_INL:     rd_data = {5'd0, inl_q};
            ADDR_KDTC_BC: rd_data = {4'd0, kdtc_bc_q};
            ADDR_KDTC_D:  rd_data = {14'd0, kdtc_d_q};
            ADDR_ID:      rd_data = ID_VALUE;
            default:      rd_data = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        rd_d      = rd_q;
        bad_d     = bad_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        ctrl_d    = ctrl_q;
        fcw_d     = fcw_q;
        pcal_d    = pcal_q;
        inl_d     = inl_q;
        kdtc_bc_d = kdtc_bc_q;
        kdtc_d_d  = kdtc_d_q;
        if (state_q != ST_IDLE && csn_rise) begin
            state_d = ST_IDLE;
            rd_d    = 1'b0;
            tx_d    = '0;
            if (state_q == ST_DONE && !bad_q && !rx_q[FRM_RW_BIT]) begin
                wr_stb_d  = 1'b1;
                wr_addr_d = rx_q[FRM_ADDR_MSB:FRM_ADDR_LSB];
                case (rx_q[FRM_ADDR_MSB:FRM_ADDR_LSB])
                    ADDR_CTRL:    ctrl_d    = rx_q[9:0];
                    ADDR_FCW:     fcw_d     = rx_q[FcwW-1:0];
                    ADDR_PCAL:    pcal_d    = rx_q[22:0];
                    ADDR_INL:     inl_d     = rx_q[18:0];
                    ADDR_KDTC_BC: kdtc_bc_d = rx_q[19:0];
                    ADDR_KDTC_D:  kdtc_d_d  = rx_q[9:0];
                    default:      ;
                endcase
            end
        end else begin
            unique case (state_q)
                ST_IDLE: if (csn_fall) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                    rx_d    = '0;
                    tx_d    = '0;
                    rd_d    = 1'b0;
                    bad_d   = 1'b0;
                end
                ST_CMD: if (sclk_rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_inc;
                    if (cnt_inc == CMD_BITS) begin
                        state_d = ST_DATA;
                        if (rx_shift[7]) begin
                            rd_d = 1'b1;
                            tx_d = rd_data;
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_rise) begin
                        rx_d  = rx_shift;
                        cnt_d = cnt_inc;
                        if (cnt_inc == FRAME_BITS) state_d = ST_DONE;
                    end
                    // Fall after the 8th rise must hold bit 23 for the 9th rise.
                    if (sclk_fall && rd_q && cnt_q > CMD_BITS) tx_d = {tx_q[22:0], 1'b0};
                end
                ST_DONE: begin
                    if (sclk_rise) bad_d = 1'b1;
                    if (sclk_fall && rd_q) tx_d = {tx_q[22:0], 1'b0};
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge NARST) begin
        if (!NARST) begin
            mosi_sync_q <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            rd_q        <= 1'b0;
            bad_q       <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            ctrl_q      <= RST_CTRL;
            fcw_q       <= FcwW'(RST_FCW);
            pcal_q      <= RST_PCAL;
            inl_q       <= RST_INL;
            kdtc_bc_q   <= RST_KDTC_BC;
            kdtc_d_q    <= RST_KDTC_D;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            rd_q        <= rd_d;
            bad_q       <= bad_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            ctrl_q      <= ctrl_d;
            fcw_q       <= fcw_d;
            pcal_q      <= pcal_d;
            inl_q       <= inl_d;
            kdtc_bc_q   <= kdtc_bc_d;
            kdtc_d_q    <= kdtc_d_d;
        end
    end

    assign spi.MISO_OE = rd_q;
    assign spi.MISO    = rd_q & tx_q[23];
    assign WR_STB      = wr_stb_q;
    assign WR_ADDR     = wr_addr_q;
    assign FCW_FOD     = fcw_q;

    assign SYS_EN           = ctrl_q[0];
    assign DSM_SYNC_NRST_EN = ctrl_q[1];
    assign NCO_SYNC_NRST_EN = ctrl_q[2];
    assign FREQ_HOP         = ctrl_q[3];
    assign RT_EN            = ctrl_q[4];
    assign PCALI_EN         = ctrl_q[5];
    assign FREQ_C_EN        = ctrl_q[6];
    assign FREQ_C_MODE      = ctrl_q[7];
    assign DTCCALI_EN       = ctrl_q[8];
    assign OFSTCALI_EN      = ctrl_q[9];

    assign FREQ_C_KS      = pcal_q[4:0];
    assign PHASE_CTRL     = pcal_q[14:5];
    assign PCALI_FREQDOWN = pcal_q[17:15];
    assign PCALI_KS       = pcal_q[22:18];

    assign PSEG      = inl_q[1:0];
    assign CALIORDER = inl_q[3:2];
    assign KB        = inl_q[8:4];
    assign KC        = inl_q[13:9];
    assign KD        = inl_q[18:14];

    assign KDTCB_INIT = kdtc_bc_q[9:0];
    assign KDTCC_INIT = kdtc_bc_q[19:10];
    assign KDTCD_INIT = kdtc_d_q;
endmodule
